// File: rtl/param_fifo_if.sv
// Bus bundle for param_fifo: request/data inputs and status/data outputs.
// The master modport drives requests; the slave modport is the FIFO side.
interface param_fifo_if #(
  parameter int unsigned DATAW = 128,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CNTW = $clog2(DEPTH + 1);

  logic             w;
  logic             r;
  logic             clr_err;
  logic [DATAW-1:0] data_in;
  logic [DATAW-1:0] data_out;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CNTW-1:0]  count;
  logic             overflow;
  logic             underflow;

  modport master (
    output w, r, clr_err, data_in,
    input  data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  w, r, clr_err, data_in,
    output data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
endinterface

// File: rtl/param_fifo.sv
// Parameterised synchronous FIFO with registered occupancy flags and sticky
// overflow/underflow errors. DEPTH need not be a power of two.
// Optional macro PARAM_FIFO_FWFT_EN selects first-word-fall-through output;
// default build uses a registered read with one cycle of latency.
module param_fifo #(
  parameter int unsigned DATAW     = 128,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AF_THRESH = 6,
  parameter int unsigned AE_THRESH = 2
) (
  input logic           clk,
  input logic           rst,
  param_fifo_if.slave   bus
);

  localparam int unsigned CNTW = $clog2(DEPTH + 1);
  localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATAW-1:0] mem_q [DEPTH];

  logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             af_q, af_d;
  logic             ae_q, ae_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic [DATAW-1:0] dout_q, dout_d;

  logic             wr_acc_c;
  logic             rd_acc_c;

  // Wrap a pointer at DEPTH-1 so non-power-of-two depths index correctly.
  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  // A write into a full FIFO is allowed only when a pop frees the slot.
  assign rd_acc_c = bus.r && !empty_q;
  assign wr_acc_c = bus.w && (!full_q || rd_acc_c);

  // Next-state for pointers, occupancy, flags, errors and read data.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    dout_d      = dout_q;

    if (wr_acc_c) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (rd_acc_c) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
      dout_d   = mem_q[rd_ptr_q];
    end

    case ({wr_acc_c, rd_acc_c})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase

    full_d  = (count_d == CNTW'(DEPTH));
    empty_d = (count_d == '0);
    af_d    = (count_d >= CNTW'(AF_THRESH));
    ae_d    = (count_d <= CNTW'(AE_THRESH));

    // A new error wins over a clear in the same cycle.
    overflow_d  = (overflow_q  && !bus.clr_err) || (bus.w && !wr_acc_c);
    underflow_d = (underflow_q && !bus.clr_err) || (bus.r && empty_q);
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      dout_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      af_q        <= af_d;
      ae_q        <= ae_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      dout_q      <= dout_d;
    end
  end

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_acc_c) begin
      mem_q[wr_ptr_q] <= bus.data_in;
    end
  end

  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

`ifdef PARAM_FIFO_FWFT_EN
  // Head entry falls through; when empty, the last popped word is held.
  assign bus.data_out = empty_q ? dout_q : mem_q[rd_ptr_q];
`else
  // Popped word appears one cycle after the accepted read and is held.
  assign bus.data_out = dout_q;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Randomised and directed bench for param_fifo: a DEPTH=8 and a DEPTH=5
// instance share stimulus and are compared against queue-based models.
module tb_param_fifo;

  localparam int unsigned DW = 8;

  logic clk;
  logic rst;

  param_fifo_if #(.DATAW(DW), .DEPTH(8)) f8 ();
  param_fifo_if #(.DATAW(DW), .DEPTH(5)) f5 ();

  param_fifo #(.DATAW(DW), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2)) u_d8 (
    .clk (clk),
    .rst (rst),
    .bus (f8)
  );

  param_fifo #(.DATAW(DW), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1)) u_d5 (
    .clk (clk),
    .rst (rst),
    .bus (f5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a queue per instance plus sticky error bits.
  int           mdepth [2] = '{8, 5};
  int           maf    [2] = '{6, 4};
  int           mae    [2] = '{2, 1};
  logic [DW-1:0] mq    [2][$];
  bit           mov    [2];
  bit           mun    [2];
  logic [DW-1:0] mlast [2];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      mov[i]   = 1'b0;
      mun[i]   = 1'b0;
      mlast[i] = '0;
    end
  endtask

  // One clock edge of the behavioural FIFO for both instances.
  task automatic model_clk(input bit w, input bit r, input logic [DW-1:0] d,
                           input bit clr);
    for (int i = 0; i < 2; i++) begin
      int  n;
      bit  racc;
      bit  wacc;
      n    = mq[i].size();
      racc = r && (n > 0);
      wacc = w && ((n < mdepth[i]) || racc);
      if (racc) mlast[i] = mq[i].pop_front();
      if (wacc) mq[i].push_back(d);
      mov[i] = (mov[i] && !clr) || (w && !wacc);
      mun[i] = (mun[i] && !clr) || (r && (n == 0));
    end
  endtask

  task automatic check_inst(input int i, input string nm,
                            input logic [31:0] cnt, input logic full,
                            input logic empty, input logic af, input logic ae,
                            input logic ov, input logic un,
                            input logic [DW-1:0] dout);
    int            n;
    logic [DW-1:0] edout;
    n = mq[i].size();
`ifdef PARAM_FIFO_FWFT_EN
    edout = (n > 0) ? mq[i][0] : mlast[i];
`else
    edout = mlast[i];
`endif
    check({nm, ".count"},        cnt,          32'(n));
    check({nm, ".full"},         32'(full),    32'(n == mdepth[i]));
    check({nm, ".empty"},        32'(empty),   32'(n == 0));
    check({nm, ".almost_full"},  32'(af),      32'(n >= maf[i]));
    check({nm, ".almost_empty"}, 32'(ae),      32'(n <= mae[i]));
    check({nm, ".overflow"},     32'(ov),      32'(mov[i]));
    check({nm, ".underflow"},    32'(un),      32'(mun[i]));
    check({nm, ".data_out"},     32'(dout),    32'(edout));
  endtask

  task automatic check_all();
    check_inst(0, "d8", 32'(f8.count), f8.full, f8.empty, f8.almost_full,
               f8.almost_empty, f8.overflow, f8.underflow, f8.data_out);
    check_inst(1, "d5", 32'(f5.count), f5.full, f5.empty, f5.almost_full,
               f5.almost_empty, f5.overflow, f5.underflow, f5.data_out);
  endtask

  task automatic drive(input bit w, input bit r, input logic [DW-1:0] d,
                       input bit clr);
    f8.w = w; f8.r = r; f8.data_in = d; f8.clr_err = clr;
    f5.w = w; f5.r = r; f5.data_in = d; f5.clr_err = clr;
  endtask

  // Drive on the falling edge, advance the model at the rising edge, check after.
  task automatic step(input bit w, input bit r, input logic [DW-1:0] d,
                      input bit clr);
    @(negedge clk);
    drive(w, r, d, clr);
    @(posedge clk);
    model_clk(w, r, d, clr);
    #1 check_all();
  endtask

  initial begin
    drive(1'b0, 1'b0, '0, 1'b0);
    rst = 1'b1;
    model_reset();
    #2 rst = 1'b0;
    #1 check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Fill 1..8: flag transitions on the way up.
    for (int k = 1; k <= 8; k++) step(1'b1, 1'b0, DW'(k), 1'b0);
    // Drain all eight in order.
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);

    // Refill, then simultaneous write/read while full.
    for (int k = 1; k <= 8; k++) step(1'b1, 1'b0, DW'(k), 1'b0);
    step(1'b1, 1'b1, DW'(9), 1'b0);
    for (int k = 0; k < 9; k++) step(1'b0, 1'b1, '0, 1'b0);

    // Underflow on empty, overflow on full, then clear.
    step(1'b0, 1'b1, '0, 1'b0);
    step(1'b1, 1'b1, DW'(3), 1'b0);
    for (int k = 1; k <= 8; k++) step(1'b1, 1'b0, DW'(10 + k), 1'b0);
    step(1'b1, 1'b0, DW'(5), 1'b0);
    step(1'b1, 1'b0, DW'(5), 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, '0, 1'b0);

    // Mid-cycle reset with a pending write held through it.
    for (int k = 1; k <= 5; k++) step(1'b1, 1'b0, DW'(k), 1'b0);
    #2 rst = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    drive(1'b1, 1'b1, DW'(8'hEE), 1'b0);
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk);
    drive(1'b0, 1'b0, '0, 1'b0);
    rst = 1'b1;
    step(1'b1, 1'b0, DW'(7), 1'b0);
    step(1'b0, 1'b1, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);

    // Prefill 3 then stream 20 words across the pointer wrap.
    for (int k = 1; k <= 3; k++) step(1'b1, 1'b0, DW'(100 + k), 1'b0);
    for (int k = 0; k < 20; k++) step(1'b1, 1'b1, DW'(k + 1), 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, '0, 1'b0);

    // Random traffic with occasional error clears.
    for (int k = 0; k < 400; k++) begin
      bit w;
      bit r;
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 45);
      step(w, r, DW'($urandom), ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
